// File: rtl/arb_pkg.sv
// Shared types and constants for the round-robin decoder-bank arbiter.
package arb_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    GRANT = 2'd1,
    GAP   = 2'd2
  } arb_state_e;

  localparam int unsigned NUM_REQ = 4;
  localparam int unsigned SEL_W   = 2;

  // Reset pointer sits on the last requester so the first search starts at req[0].
  localparam logic [SEL_W-1:0] LAST_PTR_RST = 2'd3;

endpackage

// File: rtl/decoder_2x4_gates.sv
// Gate-level 2-to-4 decoder with active-high enable; outputs are all zero when disabled.
module decoder_2x4_gates (
  input  logic [1:0] S,
  input  logic       enable,
  output logic [3:0] Y
);

  assign Y[0] = enable & ~S[1] & ~S[0];
  assign Y[1] = enable & ~S[1] &  S[0];
  assign Y[2] = enable &  S[1] & ~S[0];
  assign Y[3] = enable &  S[1] &  S[0];

endmodule

// File: rtl/decoder_rr_arbiter.sv
// Round-robin arbiter sharing one 2x4 decoder between four requesters, with
// bounded hold time and a mandatory dead cycle between owners.
module decoder_rr_arbiter
  import arb_pkg::*;
#(
  parameter int unsigned MAX_HOLD = 16,
  parameter int unsigned CNT_W    = 8
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [NUM_REQ-1:0] req,
  output logic [SEL_W-1:0]   S,
  output logic               enable,
  output logic [NUM_REQ-1:0] grant,
  output logic               busy,
  output logic               timeout
);

  localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(MAX_HOLD - 1);

  arb_state_e       state;
  logic [CNT_W-1:0] hold_cnt;
  logic [SEL_W-1:0] last_ptr;

  logic               found;
  logic [SEL_W-1:0]   winner;
  logic [NUM_REQ-1:0] own_mask;
  logic               others_waiting;

  // Rotating priority search starting just after the previous owner.
  always_comb begin
    found  = 1'b0;
    winner = '0;
    for (int unsigned k = 1; k <= NUM_REQ; k++) begin
      if (!found && req[SEL_W'(last_ptr + SEL_W'(k))]) begin
        found  = 1'b1;
        winner = SEL_W'(last_ptr + SEL_W'(k));
      end
    end
  end

  assign own_mask       = NUM_REQ'(1) << S;
  assign others_waiting = |(req & ~own_mask);

  always_ff @(posedge clk) begin
    if (reset) begin
      state    <= IDLE;
      S        <= '0;
      enable   <= 1'b0;
      busy     <= 1'b0;
      timeout  <= 1'b0;
      hold_cnt <= '0;
      last_ptr <= LAST_PTR_RST;
    end else begin
      timeout <= 1'b0;
      case (state)
        IDLE, GAP: begin
          if (found) begin
            state    <= GRANT;
            S        <= winner;
            enable   <= 1'b1;
            busy     <= 1'b1;
            hold_cnt <= '0;
          end else begin
            state  <= IDLE;
            enable <= 1'b0;
            busy   <= 1'b0;
          end
        end
        GRANT: begin
          // A release wins over an expiry on the same cycle, so no timeout then.
          if (!req[S]) begin
            state    <= GAP;
            enable   <= 1'b0;
            last_ptr <= S;
          end else if (hold_cnt == HOLD_LAST && others_waiting) begin
            state    <= GAP;
            enable   <= 1'b0;
            last_ptr <= S;
            timeout  <= 1'b1;
          end else if (hold_cnt != HOLD_LAST) begin
            hold_cnt <= hold_cnt + CNT_W'(1);
          end
        end
        default: begin
          state  <= IDLE;
          enable <= 1'b0;
          busy   <= 1'b0;
        end
      endcase
    end
  end

  decoder_2x4_gates u_dec (
    .S      (S),
    .enable (enable),
    .Y      (grant)
  );

endmodule

// File: tb/tb_decoder_rr_arbiter.sv
// Randomized and directed checks of decoder_rr_arbiter against an ownership-level model.
module tb_decoder_rr_arbiter;

  localparam int MH = 4;

  logic       clk = 1'b0;
  logic       reset;
  logic [3:0] req;
  logic [1:0] S;
  logic       enable;
  logic [3:0] grant;
  logic       busy;
  logic       timeout;

  int n_checks = 0;
  int n_pass   = 0;

  // Model: who owns the bank, whether we are in the dead cycle, cycles held so far.
  int         m_owner;
  bit         m_gap;
  int         m_held;
  int         m_last;
  logic [1:0] m_s;
  bit         m_to;

  decoder_rr_arbiter #(.MAX_HOLD(MH), .CNT_W(8)) dut (
    .clk     (clk),
    .reset   (reset),
    .req     (req),
    .S       (S),
    .enable  (enable),
    .grant   (grant),
    .busy    (busy),
    .timeout (timeout)
  );

  always #5 clk = ~clk;

  task automatic model_step(input logic [3:0] r, input logic rst);
    int w;
    int idx;
    if (rst) begin
      m_owner = -1; m_gap = 1'b0; m_held = 0; m_last = 3; m_s = 2'd0; m_to = 1'b0;
      return;
    end
    m_to = 1'b0;
    if (m_owner >= 0 && !m_gap) begin
      if (!r[m_owner]) begin
        m_gap = 1'b1; m_last = m_owner;
      end else if (m_held >= MH && (r & ~(4'b0001 << m_owner)) != 4'b0000) begin
        m_gap = 1'b1; m_last = m_owner; m_to = 1'b1;
      end else begin
        m_held++;
      end
    end else begin
      w = -1;
      for (int k = 1; k <= 4; k++) begin
        idx = (m_last + k) % 4;
        if (w < 0 && r[idx]) w = idx;
      end
      m_gap = 1'b0;
      if (w >= 0) begin
        m_owner = w; m_held = 1; m_s = 2'(w);
      end else begin
        m_owner = -1;
      end
    end
  endtask

  function automatic logic [8:0] exp_vec();
    logic [3:0] g;
    g = (m_owner >= 0 && !m_gap) ? 4'(4'b0001 << m_owner) : 4'b0000;
    return {m_s, (g != 4'b0000), g, (m_owner >= 0), m_to};
  endfunction

  task automatic drive(input logic [3:0] r, input logic rst);
    req   = r;
    reset = rst;
    @(posedge clk);
    model_step(r, rst);
    @(negedge clk);
  endtask

  task automatic test_reset();
    drive(4'b0000, 1'b1);
    n_checks++;
    if ({S, enable, grant, busy, timeout} !== 9'b0) $display("FAIL reset_state: got %b expected %b", {S, enable, grant, busy, timeout}, 9'b0);
    else n_pass++;
    for (int i = 0; i < 10; i++) begin
      drive(4'b0000, 1'b0);
      n_checks++;
      if ({S, enable, grant, busy, timeout} !== 9'b0) $display("FAIL idle_no_req cyc %0d: got %b expected %b", i, {S, enable, grant, busy, timeout}, 9'b0);
      else n_pass++;
    end
  endtask

  task automatic test_release();
    drive(4'b1010, 1'b0);
    n_checks++;
    if (S !== 2'd1 || grant !== 4'b0010) $display("FAIL release_first S=%0d grant=%b expected S=1 grant=0010", S, grant);
    else n_pass++;
    drive(4'b1000, 1'b0);
    n_checks++;
    if (grant !== 4'b0000 || busy !== 1'b1 || S !== 2'd1) $display("FAIL release_gap grant=%b busy=%b S=%0d expected 0000 1 1", grant, busy, S);
    else n_pass++;
    drive(4'b1000, 1'b0);
    n_checks++;
    if (grant !== 4'b1000) $display("FAIL release_next grant=%b expected 1000", grant);
    else n_pass++;
    for (int i = 0; i < 3; i++) begin
      drive(4'b0000, 1'b0);
      n_checks++;
      if ({S, enable, grant, busy, timeout} !== exp_vec()) $display("FAIL release_drain cyc %0d: got %b expected %b", i, {S, enable, grant, busy, timeout}, exp_vec());
      else n_pass++;
    end
  endtask

  task automatic test_rotation();
    logic [3:0] seq [0:12];
    seq = '{4'b0001, 4'b0001, 4'b0001, 4'b0001, 4'b0000,
            4'b0010, 4'b0010, 4'b0010, 4'b0010, 4'b0000,
            4'b0100, 4'b0100, 4'b0100};
    drive(4'b0000, 1'b1);
    for (int i = 0; i < 13; i++) begin
      drive(4'b1111, 1'b0);
      n_checks++;
      if (grant !== seq[i] || timeout !== (i == 4 || i == 9)) $display("FAIL rotation cyc %0d: grant=%b timeout=%b expected grant=%b timeout=%b", i, grant, timeout, seq[i], (i == 4 || i == 9));
      else n_pass++;
    end
    for (int i = 13; i < 24; i++) begin
      drive(4'b1111, 1'b0);
      n_checks++;
      if ({S, enable, grant, busy, timeout} !== exp_vec()) $display("FAIL rotation_model cyc %0d: got %b expected %b", i, {S, enable, grant, busy, timeout}, exp_vec());
      else n_pass++;
    end
    n_checks++;
    if (grant !== 4'b0001) $display("FAIL rotation_wrap grant=%b expected 0001", grant);
    else n_pass++;
  endtask

  task automatic test_sole_requester();
    drive(4'b0000, 1'b1);
    for (int i = 0; i < 40; i++) begin
      drive(4'b0100, 1'b0);
      n_checks++;
      if (grant !== 4'b0100 || timeout !== 1'b0) $display("FAIL sole_hold cyc %0d: grant=%b timeout=%b expected 0100 0", i, grant, timeout);
      else n_pass++;
    end
  endtask

  task automatic test_reset_mid_grant();
    drive(4'b0000, 1'b1);
    drive(4'b1000, 1'b0);
    n_checks++;
    if (grant !== 4'b1000) $display("FAIL midreset_owner grant=%b expected 1000", grant);
    else n_pass++;
    drive(4'b1111, 1'b1);
    n_checks++;
    if ({S, enable, grant, busy, timeout} !== 9'b0) $display("FAIL midreset_drop got %b expected %b", {S, enable, grant, busy, timeout}, 9'b0);
    else n_pass++;
    drive(4'b1111, 1'b0);
    n_checks++;
    if (grant !== 4'b0001) $display("FAIL midreset_next grant=%b expected 0001", grant);
    else n_pass++;
  endtask

  task automatic test_release_at_expiry();
    drive(4'b0000, 1'b1);
    drive(4'b0110, 1'b0);
    for (int i = 0; i < MH - 1; i++) drive(4'b0110, 1'b0);
    n_checks++;
    if (grant !== 4'b0010) $display("FAIL expiry_owner grant=%b expected 0010", grant);
    else n_pass++;
    drive(4'b0100, 1'b0);
    n_checks++;
    if (grant !== 4'b0000 || timeout !== 1'b0) $display("FAIL expiry_release grant=%b timeout=%b expected 0000 0", grant, timeout);
    else n_pass++;
    drive(4'b0100, 1'b0);
    n_checks++;
    if (grant !== 4'b0100) $display("FAIL expiry_next grant=%b expected 0100", grant);
    else n_pass++;
  endtask

  task automatic test_random();
    logic [3:0] r;
    logic [3:0] prev;
    logic       rst;
    r    = 4'b0000;
    prev = 4'b0000;
    drive(4'b0000, 1'b1);
    for (int i = 0; i < 600; i++) begin
      for (int b = 0; b < 4; b++) if ($urandom_range(0, 5) == 0) r[b] = ~r[b];
      rst = ($urandom_range(0, 59) == 0);
      drive(r, rst);
      n_checks++;
      if ({S, enable, grant, busy, timeout} !== exp_vec()) $display("FAIL random_model cyc %0d: got %b expected %b", i, {S, enable, grant, busy, timeout}, exp_vec());
      else n_pass++;
      n_checks++;
      if ($countones(grant) > 1 || (prev != 4'b0000 && grant != 4'b0000 && grant != prev)) $display("FAIL random_exclusive cyc %0d: grant=%b prev=%b", i, grant, prev);
      else n_pass++;
      prev = grant;
    end
  endtask

  initial begin
    reset = 1'b1;
    req   = 4'b0000;
    m_owner = -1; m_gap = 1'b0; m_held = 0; m_last = 3; m_s = 2'd0; m_to = 1'b0;
    @(negedge clk);
    test_reset();
    test_release();
    test_rotation();
    test_sole_requester();
    test_reset_mid_grant();
    test_release_at_expiry();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
